// File: rtl/fifo_thresh.sv
// fifo_thresh: single-clock FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, sticky error flags and optional FWFT read port.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   wr_en, wr_data    write request and word
//   rd_en             read request (pop of the shown word in FWFT mode)
//   rd_data, rd_valid read word and its valid qualifier
//   full, empty       count == data_depth / count == 0
//   almost_full       count >= afull_thresh
//   almost_empty      count <= aempty_thresh
//   count             occupancy, 0..data_depth
//   overflow          sticky: write request that was rejected
//   underflow         sticky: read request that was rejected
//   clr_err           clears overflow/underflow (a same-cycle set wins)
module fifo_thresh #(
    parameter int data_width    = 10,
    parameter int addr_width    = 4,
    parameter int data_depth    = 16,
    parameter int afull_thresh  = 12,
    parameter int aempty_thresh = 2,
    parameter int fwft          = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [data_width-1:0] wr_data,
    input  logic                  rd_en,
    output logic [data_width-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [addr_width:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    if (data_depth != 2 ** addr_width) begin : g_bad_depth
        $error("fifo_thresh: data_depth must equal 2**addr_width");
    end
    if (afull_thresh < 1 || afull_thresh > data_depth) begin : g_bad_afull
        $error("fifo_thresh: afull_thresh out of range");
    end
    if (aempty_thresh < 0 || aempty_thresh > data_depth - 1) begin : g_bad_aempty
        $error("fifo_thresh: aempty_thresh out of range");
    end

    localparam logic [addr_width:0] depth_c  = (addr_width + 1)'(data_depth);
    localparam logic [addr_width:0] afull_c  = (addr_width + 1)'(afull_thresh);
    localparam logic [addr_width:0] aempty_c = (addr_width + 1)'(aempty_thresh);

    logic [data_width-1:0] mem [data_depth];
    logic [addr_width-1:0] wr_ptr;
    logic [addr_width-1:0] rd_ptr;
    logic [addr_width:0]   count_next;
    logic                  rd_acc;
    logic                  wr_acc;

    // A full FIFO still takes a write when a read frees a slot the same cycle.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_next = count - 1'b1;
        end
    end

    // Storage is not reset; requests in the reset cycle are ignored.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Status flags decode next-count so they line up with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == depth_c);
            almost_empty <= (count_next <= aempty_c);
            almost_full  <= (count_next >= afull_c);
            overflow     <= (overflow & ~clr_err) | (wr_en & ~wr_acc);
            underflow    <= (underflow & ~clr_err) | (rd_en & ~rd_acc);
        end
    end

    if (fwft != 0) begin : g_fwft
        // Head word is always presented; rd_en acknowledges it.
        assign rd_data  = mem[rd_ptr];
        assign rd_valid = ~empty;
    end else begin : g_std
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end else if (rd_acc) begin
                rd_data  <= mem[rd_ptr];
                rd_valid <= 1'b1;
            end else begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fifo_thresh.md
Name: fifo_thresh

Overview:
Parametrised single-clock synchronous FIFO and successor to the basic fifo block. It adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags with clear, a read-valid strobe, and a compile-time first-word-fall-through (FWFT) mode. It is the general-purpose buffer between producer/consumer stages in one clock domain.

Parameters:
data_width, 10, word width in bits
addr_width, 4, pointer width; depth = 2**addr_width
data_depth, 16, storage words; must equal 2**addr_width (elaboration error otherwise)
afull_thresh, 12, almost_full asserted when count >= afull_thresh (1..data_depth)
aempty_thresh, 2, almost_empty asserted when count <= aempty_thresh (0..data_depth-1)
fwft, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
wr_en  input  1  write request
wr_data  input  data_width  write word
rd_en  input  1  read request (pop in FWFT mode)
rd_data  output  data_width  read word
rd_valid  output  1  rd_data holds a valid word
full  output  1  count == data_depth
empty  output  1  count == 0
almost_full  output  1  count >= afull_thresh
almost_empty  output  1  count <= aempty_thresh
count  output  addr_width+1  current occupancy, 0..data_depth
overflow  output  1  sticky: write attempted while not accepted
underflow  output  1  sticky: read attempted while not accepted
clr_err  input  1  clears overflow/underflow

Behaviour:
- Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=underflow=0, rd_valid=0, rd_data=0 (standard mode). Memory contents are not reset.
- Reset asserted mid-operation discards all contents. Requests in the reset cycle are ignored.
- rd_acc = rd_en & ~empty.
- wr_acc = wr_en & (~full | rd_acc). A simultaneous read and write on a full FIFO are both accepted.
- An empty FIFO never accepts a read, even with a simultaneous write. The write is accepted.
- Write: mem[wr_ptr] <= wr_data; wr_ptr increments and wraps modulo data_depth naturally at addr_width bits.
- Read: rd_ptr increments and wraps likewise.
- count update per cycle: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
- full, empty, almost_full and almost_empty are registered and decoded from next-count, so they are valid in the same cycle count updates (one cycle after the request edge).
- Standard mode (fwft=0): on rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1; otherwise rd_valid <= 0 and rd_data holds. Read latency is 1 cycle.
- FWFT mode (fwft=1): rd_data = mem[rd_ptr] combinationally and rd_valid = ~empty. rd_en acknowledges/pops the shown word.
- FWFT: a word written into an empty FIFO appears on rd_data one cycle after its write edge.
- overflow <= 1 when wr_en & ~wr_acc; underflow <= 1 when rd_en & ~rd_acc.
- clr_err=1 clears both flags. If set and clear occur in the same cycle, set wins.
- Rejected requests never modify pointers, count or memory.

Test Plan:
- Reset then write 0..9 (10 cycles) -> count=10, empty=0, almost_empty=0, almost_full=0, full=0; no error flags.
- Standard mode: read 3 -> rd_data 0,1,2, each with rd_valid one cycle after its rd_en; count=7.
- Fill to 16 (write 88,11,12,...) -> almost_full at count 12, full at 16. An extra write sets overflow, count stays 16, and the word is not stored. clr_err clears overflow.
- Full FIFO with rd_en=wr_en=1 and wr_data=33 -> both accepted, count stays 16, oldest word read out, 33 later read last. Pointer wrap past index 15 is verified by reading all 16 entries in order.
- Empty FIFO with rd_en=1 -> underflow=1, rd_valid=0, count=0. Then rd_en=wr_en=1 with data 5 -> write only, count=1, underflow remains set.
- fwft=1: write 7 into empty -> next cycle rd_valid=1, rd_data=7 with no rd_en. rd_en pops it -> empty=1, rd_valid=0. Assert rst mid-stream with count=5 -> next cycle count=0, empty=1.
